// File: rtl/debounce_sync_filter.sv
// rtl/debounce_sync_filter.sv - synchronizer + debounce FSM; rise/fall outputs built only with DEBOUNCE_SYNC_FILTER_EDGE_OUT_EN
module debounce_sync_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  output logic a,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic                   sync_q;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   a_q, a_d;
  logic                   busy_q, busy_d;

  // Only the deepest stage feeds the FSM; earlier stages absorb metastability.
  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  // Shift the raw level through the synchronizer chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_chain_q <= '0;
    end else begin
      sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], a_raw};
    end
  end

  // Next-state and hold-counter logic; cnt stops at CNT_MAX so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: begin
        if (sync_q) begin
          state_d = CHECK_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      STABLE_HI: begin
        if (!sync_q) begin
          state_d = CHECK_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      CHECK_HI: begin
        if (sync_q) begin
          if (cnt_q == CNT_MAX) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      end
      CHECK_LO: begin
        if (!sync_q) begin
          if (cnt_q == CNT_MAX) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Level and busy are decoded from the next state so they register alongside it.
  always_comb begin
    a_d    = (state_d == STABLE_HI) || (state_d == CHECK_LO);
    busy_d = (state_d == CHECK_HI)  || (state_d == CHECK_LO);
  end

  // FSM state, counter and registered level/busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
    end
  end

  assign a    = a_q;
  assign busy = busy_q;

`ifdef DEBOUNCE_SYNC_FILTER_EDGE_OUT_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // A pulse fires only on a qualified CHECK->STABLE completion, never on a glitch return.
  always_comb begin
    rise_d = (state_q == CHECK_HI) && (state_d == STABLE_HI);
    fall_d = (state_q == CHECK_LO) && (state_d == STABLE_LO);
  end

  // Edge pulses share the cycle in which a first shows its new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync_filter.sv
// tb/tb_debounce_sync_filter.sv - scoreboard bench for debounce_sync_filter
module tb_debounce_sync_filter;

  localparam int S = 2;
  localparam int D = 4;
`ifdef DEBOUNCE_SYNC_FILTER_EDGE_OUT_EN
  localparam int EDGE_EN = 1;
`else
  localparam int EDGE_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic a_raw;
  logic a, rise, fall, busy;

  always #5 clk = ~clk;

  debounce_sync_filter #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .a_raw(a_raw),
    .a    (a),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
  endtask

  // Reference model: a flips once the last D+1 observed (synchronized) samples
  // all disagree with it; observations lag the raw input by S edges.
  logic [3:0] exp_q[$];
  bit         pipe[$];
  bit         win[$];
  bit         m_a;

  function automatic void model_reset();
    pipe.delete();
    for (int i = 0; i < S; i++) pipe.push_back(1'b0);
    win.delete();
    m_a = 1'b0;
  endfunction

  function automatic logic [3:0] model_step(input bit raw);
    bit obs, prev, all_diff, m_busy, m_rise, m_fall;
    obs = pipe.pop_front();
    pipe.push_back(raw);
    win.push_back(obs);
    if (win.size() > D + 1) void'(win.pop_front());
    prev = m_a;
    if (win.size() == D + 1) begin
      all_diff = 1'b1;
      foreach (win[i]) if (win[i] == m_a) all_diff = 1'b0;
      if (all_diff) m_a = !m_a;
    end
    m_busy = (obs != m_a);
    m_rise = (EDGE_EN != 0) && m_a && !prev;
    m_fall = (EDGE_EN != 0) && !m_a && prev;
    return {m_a, m_rise, m_fall, m_busy};
  endfunction

  task automatic cycle(input bit rv, input bit val);
    @(negedge clk);
    rst   = rv;
    a_raw = val;
    if (!rv) begin
      model_reset();
      exp_q.push_back(4'b0000);
    end else begin
      exp_q.push_back(model_step(val));
    end
  endtask

  task automatic run(input bit rv, input bit val, input int n);
    for (int i = 0; i < n; i++) cycle(rv, val);
  endtask

  // Monitor: pops one expectation per clock and records level/pulse events.
  int         mon_cyc   = 0;
  bit         prev_a_m  = 1'b0;
  int         a_ups     = 0;
  int         a_dns     = 0;
  int         rise_n    = 0;
  int         fall_n    = 0;
  int         busy_n    = 0;
  int         a_up_edge = -1;
  int         a_dn_edge = -1;
  logic [3:0] mon_e;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("sb_a_rise_fall_busy", int'({a, rise, fall, busy}), int'(mon_e));
        chk("rise_fall_exclusive", int'(rise & fall), 0);
      end
      if (a && !prev_a_m) begin a_ups++; a_up_edge = mon_cyc; end
      if (!a && prev_a_m) begin a_dns++; a_dn_edge = mon_cyc; end
      if (rise) rise_n++;
      if (fall) fall_n++;
      if (busy) busy_n++;
      prev_a_m = a;
      mon_cyc++;
    end
  end

  int start, r0, f0, b0, u0, d0;

  initial begin
    rst   = 1'b0;
    a_raw = 1'b0;
    model_reset();
    #1;
    chk("reset_a",    int'(a),         0);
    chk("reset_rise", int'(rise),      0);
    chk("reset_fall", int'(fall),      0);
    chk("reset_busy", int'(busy),      0);
    chk("reset_cnt",  int'(dut.cnt_q), 0);
    run(1'b0, 1'b0, 3);
    run(1'b1, 1'b0, 8);

    // clean step
    r0 = rise_n; b0 = busy_n;
    cycle(1'b1, 1'b1);
    start = mon_cyc;
    run(1'b1, 1'b1, 11);
    chk("step_latency",     a_up_edge - start, S + D);
    chk("step_busy_cycles", busy_n - b0,       D);
    chk("step_rise_pulses", rise_n - r0,       EDGE_EN);
    chk("step_a_high",      int'(a),           1);
    run(1'b1, 1'b0, 12);

    // glitch of exactly D clocks is rejected
    u0 = a_ups; b0 = busy_n; r0 = rise_n;
    run(1'b1, 1'b1, D);
    run(1'b1, 1'b0, 12);
    chk("glitch_a_unchanged", a_ups - u0,  0);
    chk("glitch_no_rise",     rise_n - r0, 0);
    chk("glitch_busy_cycles", busy_n - b0, D);
    chk("glitch_busy_idle",   int'(busy),  0);

    // D+1 clocks is accepted, then released
    u0 = a_ups; d0 = a_dns; r0 = rise_n; f0 = fall_n;
    run(1'b1, 1'b1, D + 1);
    run(1'b1, 1'b0, 14);
    chk("thr_a_rises",   a_ups - u0,              1);
    chk("thr_a_falls",   a_dns - d0,              1);
    chk("thr_spacing",   a_dn_edge - a_up_edge,   D + 1);
    chk("thr_rise_cnt",  rise_n - r0,             EDGE_EN);
    chk("thr_fall_cnt",  fall_n - f0,             EDGE_EN);

    // chatter every 2 clocks, then hold high
    u0 = a_ups;
    for (int i = 0; i < 40; i++) cycle(1'b1, bit'(((i / 2) + 1) % 2));
    chk("chatter_no_change", a_ups - u0, 0);
    cycle(1'b1, 1'b1);
    start = mon_cyc;
    run(1'b1, 1'b1, 11);
    chk("chatter_latency", a_up_edge - start, S + D);
    run(1'b1, 1'b0, 12);

    // reset in the third CHECK_HI cycle
    r0 = rise_n; u0 = a_ups;
    run(1'b1, 1'b1, 5);
    @(posedge clk);
    #2;
    chk("midchk_busy_before", int'(busy),      1);
    chk("midchk_cnt_before",  int'(dut.cnt_q), 3);
    cycle(1'b0, 1'b1);
    #1;
    chk("midchk_a",    int'(a),         0);
    chk("midchk_busy", int'(busy),      0);
    chk("midchk_cnt",  int'(dut.cnt_q), 0);
    run(1'b0, 1'b1, 2);
    chk("midchk_no_rise", rise_n - r0, 0);
    chk("midchk_no_a",    a_ups - u0,  0);
    cycle(1'b1, 1'b1);
    start = mon_cyc;
    run(1'b1, 1'b1, 11);
    chk("release_latency", a_up_edge - start, S + D);
    chk("release_rise",    rise_n - r0,       EDGE_EN);

    // randomized runs with occasional resets
    for (int r = 0; r < 80; r++) begin
      int len;
      bit v;
      len = int'($urandom_range(1, 2 * D + 2));
      v   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) run(1'b0, v, int'($urandom_range(1, 2)));
      else run(1'b1, v, len);
    end
    run(1'b1, 1'b0, 12);
    @(posedge clk);
    #2;
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/debounce_sync_filter.md
DEBOUNCE_SYNC_FILTER -- requirements
Module: debounce_sync_filter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops; legal range 2 or more.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, hold-count threshold; legal range 1 or more.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state is on posedge clk.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port a_raw, input, 1 bit, asynchronous noisy level such as a button or external pin.
REQ-006 The block SHALL have port a, output, 1 bit, debounced stable level, registered, intended to drive downstream edge and pulse detectors.
REQ-007 The block SHALL have port rise, output, 1 bit, one-cycle pulse on each 0->1 change of a.
REQ-008 The block SHALL have port fall, output, 1 bit, one-cycle pulse on each 1->0 change of a.
REQ-009 The block SHALL have port busy, output, 1 bit, high while a candidate level change is being qualified.

Function
REQ-010 a_raw SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage, sync_q, is used by the logic.
REQ-011 The FSM SHALL have states STABLE_LO, CHECK_HI, STABLE_HI and CHECK_LO; a SHALL be 1 in STABLE_HI and CHECK_LO, and 0 otherwise.
REQ-012 From STABLE_x, when sync_q differs from a, the FSM SHALL go to CHECK_(not x) and load cnt with 1; otherwise it SHALL stay with cnt at 0.
REQ-013 In CHECK_y with sync_q equal to y and cnt equal to DEBOUNCE_CYCLES, the FSM SHALL go to STABLE_y, clear cnt and flip a at that edge.
REQ-014 In CHECK_y with sync_q equal to y and cnt below DEBOUNCE_CYCLES, cnt SHALL increment by 1.
REQ-015 In CHECK_y with sync_q not equal to y (glitch), the FSM SHALL return to its STABLE state, clear cnt, and leave a and the pulse outputs unchanged.
REQ-016 cnt SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL never wrap.
REQ-017 Latency: with the edge that samples a new a_raw value counted as edge 0, a SHALL change at edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-018 A raw pulse lasting DEBOUNCE_CYCLES clocks or fewer SHALL never change a; a raw pulse lasting DEBOUNCE_CYCLES+1 clocks or more SHALL always change a.
REQ-019 rise and fall SHALL be registered and SHALL assert for exactly the first cycle in which a holds its new value; they SHALL never both be high.
REQ-020 busy SHALL be high exactly while the FSM is in CHECK_HI or CHECK_LO.
REQ-021 The block SHALL accept back-to-back qualified changes; the minimum spacing between a rise and the following fall SHALL be DEBOUNCE_CYCLES+1 cycles.

Reset
REQ-022 On rst low, the block SHALL immediately clear all sync flops, set the FSM to STABLE_LO, and drive cnt, a, rise, fall and busy to 0.
REQ-023 If reset asserts mid-CHECK, the pending change SHALL be discarded and no rise or fall pulse SHALL be emitted.
REQ-024 After reset release with a_raw held at 1, a SHALL rise after the full REQ-017 latency, accompanied by one rise pulse.

Configuration
REQ-025 The macro DEBOUNCE_SYNC_FILTER_EDGE_OUT_EN SHALL control the edge outputs.
REQ-026 With DEBOUNCE_SYNC_FILTER_EDGE_OUT_EN defined, rise and fall SHALL behave per REQ-019.
REQ-027 With DEBOUNCE_SYNC_FILTER_EDGE_OUT_EN undefined, rise and fall SHALL be tied to 0 and their registers SHALL be omitted; all other behaviour SHALL be unchanged.

Verification
Defaults apply to every scenario: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, DEBOUNCE_SYNC_FILTER_EDGE_OUT_EN defined.
REQ-028 Clean step: a_raw 0->1 sampled at edge 0 and held -> a=1 from edge 6, rise=1 for one cycle only, busy=1 for 4 cycles.
REQ-029 Glitch reject: a_raw high for 4 clocks, then low -> a stays 0, rise never asserts, busy returns to 0.
REQ-030 Threshold accept: a_raw high for 5 clocks, then low -> a goes 1 then 0, with one rise and one fall pulse at 5-cycle spacing.
REQ-031 Chatter: a_raw toggles every 2 clocks for 40 clocks, then is held at 1 -> a stays 0 during chatter and rises 6 edges after the final sampled 0->1.
REQ-032 Mid-check reset: rst driven low in the 3rd CHECK_HI cycle -> a, busy and cnt are 0 immediately, and no rise pulse occurs.
REQ-033 Macro off: repeat the clean-step scenario with the macro undefined -> identical a and busy timing, with rise and fall held at 0.
